// File: rtl/drain_collector_pkg.sv
// drain_collector_pkg: shared DATA_WIDTH define, ACC_WIDTH default, FSM states and the shift-and-saturate helper
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
package drain_collector_pkg;
  localparam int ACC_WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] a, input logic [4:0] sh, input int dw);
    logic signed [63:0] s, hi, lo;
    s = a >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/drain_collector_if.sv
// drain_collector_if: tile control, skewed array columns and requantized row stream; master = collector, slave = array/downstream
interface drain_collector_if
  import drain_collector_pkg::*;
#(
  parameter int N = 4,
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic start;
  logic [4:0] shift;
  logic busy;
  logic done;
  logic drain_enable;
  logic acc_clear;
  logic [ACC_WIDTH-1:0] drain_data [N];
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data [N];
  logic [$clog2(N)-1:0] out_row;
  logic out_last;
  modport master (
    input start, shift, drain_data, out_ready,
    output busy, done, drain_enable, acc_clear, out_valid, out_data, out_row, out_last
  );
  modport slave (
    output start, shift, drain_data, out_ready,
    input busy, done, drain_enable, acc_clear, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/drain_collector_row_fifo.sv
// row_fifo: DEPTH-entry FIFO of packed rows; ports clk, rst, push_i/din_i, pop_i, dout_o (head), empty_o
module row_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;
  logic wr_en, rd_en;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = cnt_q == '0;
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (cnt_q != CNTW'(DEPTH) || rd_en);
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
    wr_q <= rst ? '0 : wr_en ? nxt(wr_q) : wr_q;
    rd_q <= rst ? '0 : rd_en ? nxt(rd_q) : rd_q;
    cnt_q <= rst ? '0 : cnt_q + CNTW'(wr_en) - CNTW'(rd_en);
  end
endmodule

// File: rtl/drain_collector.sv
// drain_collector: drains one N x N tile, deskews columns, requantizes and streams rows; ports clk, rst, bus (drain_collector_if.master)
module drain_collector
  import drain_collector_pkg::*;
#(
  parameter int N = 4,
  parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input logic clk,
  input logic rst,
  drain_collector_if.master bus
);
  localparam int CW = $clog2(2 * N + 1);
  localparam int RW = $clog2(N);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [4:0] shift_q, shift_d;
  logic [ACC_WIDTH-1:0] al [N];
  logic [N*DATA_WIDTH-1:0] din, dout;
  logic push, pop, empty;
  assign push = state_q == DRAIN && cnt_q >= CW'(N + 1);
  assign pop = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q <= rst ? '0 : cnt_d;
    row_q <= rst ? '0 : row_d;
    shift_q <= rst ? '0 : shift_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = pop ? row_q + 1'b1 : row_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = DRAIN;
        cnt_d = CW'(1);
        row_d = '0;
        shift_d = bus.shift;
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(2 * N) ? FLUSH : DRAIN;
      end
      FLUSH: state_d = pop && row_q == RW'(N - 1) ? DONE : FLUSH;
      DONE: state_d = IDLE;
    endcase
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.drain_enable = state_q == DRAIN && cnt_q <= CW'(2 * N - 1);
  assign bus.acc_clear = state_q == DRAIN && cnt_q == CW'(2 * N);
  assign bus.out_valid = !empty;
  assign bus.out_row = row_q;
  assign bus.out_last = row_q == RW'(N - 1);
  for (genvar c = 0; c < N; c++) begin : g_col
    if (c == N - 1) begin : g_pass
      assign al[c] = bus.drain_data[c];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] d_q [N-1-c];
      always_ff @(posedge clk) begin
        d_q[0] <= rst ? '0 : bus.drain_data[c];
        for (int k = 1; k < N - 1 - c; k++) d_q[k] <= rst ? '0 : d_q[k-1];
      end
      assign al[c] = d_q[N-2-c];
    end
    assign din[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(shift_sat(64'($signed(al[c])), shift_q, DATA_WIDTH));
    assign bus.out_data[c] = empty ? '0 : dout[c*DATA_WIDTH +: DATA_WIDTH];
  end
  row_fifo #(.DEPTH(N), .W(N * DATA_WIDTH)) u_row_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .din_i(din),
    .dout_o(dout),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_drain_collector.sv
// tb_drain_collector: directed tiles with an expected-row queue checked by a separate output monitor
module tb_drain_collector;
  import drain_collector_pkg::*;
  localparam int N = 4;
  typedef struct packed {
    logic [N-1:0][15:0] d;
    logic [1:0] row;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  drain_collector_if #(.N(N), .ACC_WIDTH(32), .DATA_WIDTH(16)) bus ();
  drain_collector #(.N(N), .ACC_WIDTH(32), .DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t exp_q[$];
  logic [31:0] mat [N][N];
  logic [31:0] vec [4] = '{32'h7FFF_0000, 32'h8001_0000, 32'h0000_0100, 32'hFFFF_FFEF};
  logic [15:0] expv [4] = '{16'h7FFF, 16'h8000, 16'h0010, 16'hFFFE};
  logic [N-1:0][15:0] act_d;
  logic en_prev = 0;
  int cyc = 0, t0 = -1000, checks = 0, errors = 0;
  int en_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int en_rise = -1, clr_cyc = -1, pop0_cyc = -1, pop3_cyc = -1;
  int b_en, b_clr, b_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic load(input int base);
    exp_t e;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mat[r][c] = 32'(base + 10 * r + c);
        e.d[c] = 16'(base + 10 * r + c);
      end
      e.row = 2'(r);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_tile(input logic [4:0] sh);
    bus.shift = sh;
    bus.start = 1;
    t0 = cyc;
    tick();
    bus.start = 0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int lim;
    lim = cyc + budget;
    while (done_cnt == base && cyc < lim) tick();
    chk("done_seen", 64'(done_cnt - base), 1);
  endtask

  task automatic snap();
    b_en = en_cnt;
    b_clr = clr_cnt;
    b_done = done_cnt;
  endtask

  // Systolic array model: element (r,c) appears on column c at cycle t0+2+r+c, junk otherwise.
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    for (int c = 0; c < N; c++) begin
      int k;
      k = cyc - t0 - 2 - c;
      bus.drain_data[c] = (k >= 0 && k < N) ? mat[k][c] : 32'h0BAD_0000 + 32'(c);
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.drain_enable && !en_prev) en_rise = cyc;
    en_prev = bus.drain_enable;
    if (bus.drain_enable) en_cnt++;
    if (bus.acc_clear) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_after_last_row", 64'(cyc), 64'(pop3_cyc + 1));
    end
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got row %0d expected none", bus.out_row);
      end else begin
        for (int c = 0; c < N; c++) act_d[c] = bus.out_data[c];
        chk("row_data", act_d, exp_q[0].d);
        chk("row_index", 64'(bus.out_row), 64'(exp_q[0].row));
        chk("row_last", 64'(bus.out_last), 64'(exp_q[0].row == 2'd3));
        if (bus.out_ready) begin
          if (exp_q[0].row == 2'd0) pop0_cyc = cyc;
          if (exp_q[0].row == 2'd3) pop3_cyc = cyc;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.start = 0;
    bus.shift = 0;
    bus.out_ready = 0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mat[r][c] = '0;
    repeat (3) tick();
    @(negedge clk);
    for (int c = 0; c < N; c++) act_d[c] = bus.out_data[c];
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_drain_enable", 64'(bus.drain_enable), 0);
    chk("rst_acc_clear", 64'(bus.acc_clear), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_row", 64'(bus.out_row), 0);
    chk("rst_out_data", act_d, 0);
    tick();
    rst = 0;
    tick();
    // ready held high, shift 0, element 10r+c
    bus.out_ready = 1;
    load(0);
    snap();
    start_tile(0);
    wait_done(b_done, 40);
    chk("t1_en_count", 64'(en_cnt - b_en), 7);
    chk("t1_en_first", 64'(en_rise), 64'(t0 + 1));
    chk("t1_clr_count", 64'(clr_cnt - b_clr), 1);
    chk("t1_clr_cycle", 64'(clr_cyc), 64'(t0 + 8));
    chk("t1_first_pop", 64'(pop0_cyc), 64'(t0 + 6));
    chk("t1_last_pop", 64'(pop3_cyc), 64'(t0 + 9));
    chk("t1_drained", 64'(exp_q.size()), 0);
    tick();
    // ready low until drain completes
    bus.out_ready = 0;
    load(100);
    snap();
    start_tile(0);
    go_to(t0 + 11);
    @(negedge clk);
    chk("t2_held_valid", 64'(bus.out_valid), 1);
    tick();
    bus.out_ready = 1;
    wait_done(b_done, 40);
    chk("t2_first_pop", 64'(pop0_cyc), 64'(t0 + 12));
    chk("t2_last_pop", 64'(pop3_cyc), 64'(t0 + 15));
    chk("t2_drained", 64'(exp_q.size()), 0);
    tick();
    // shift 4 saturation; shift changed after start must not matter
    for (int r = 0; r < N; r++) begin
      exp_t e;
      for (int c = 0; c < N; c++) begin
        mat[r][c] = vec[(r + c) % 4];
        e.d[c] = expv[(r + c) % 4];
      end
      e.row = 2'(r);
      exp_q.push_back(e);
    end
    snap();
    start_tile(4);
    bus.shift = 5'd31;
    wait_done(b_done, 40);
    chk("t3_drained", 64'(exp_q.size()), 0);
    tick();
    // start ignored during DRAIN and on the done cycle
    load(40);
    snap();
    start_tile(0);
    go_to(t0 + 3);
    bus.start = 1;
    tick();
    bus.start = 0;
    go_to(t0 + 10);
    bus.start = 1;
    @(negedge clk);
    chk("t4_done_pulse", 64'(bus.done), 1);
    tick();
    bus.start = 0;
    @(negedge clk);
    chk("t4_idle_after_done", 64'(bus.busy), 0);
    chk("t4_no_restart", 64'(bus.drain_enable), 0);
    repeat (4) tick();
    chk("t4_en_count", 64'(en_cnt - b_en), 7);
    chk("t4_clr_count", 64'(clr_cnt - b_clr), 1);
    chk("t4_done_count", 64'(done_cnt - b_done), 1);
    chk("t4_drained", 64'(exp_q.size()), 0);
    // reset two cycles into DRAIN, then restart right after reset falls
    load(200);
    snap();
    start_tile(0);
    go_to(t0 + 2);
    rst = 1;
    tick();
    rst = 0;
    exp_q.delete();
    load(200);
    bus.shift = 0;
    bus.start = 1;
    t0 = cyc;
    @(negedge clk);
    for (int c = 0; c < N; c++) act_d[c] = bus.out_data[c];
    chk("t5_busy", 64'(bus.busy), 0);
    chk("t5_done", 64'(bus.done), 0);
    chk("t5_drain_enable", 64'(bus.drain_enable), 0);
    chk("t5_acc_clear", 64'(bus.acc_clear), 0);
    chk("t5_out_valid", 64'(bus.out_valid), 0);
    chk("t5_out_row", 64'(bus.out_row), 0);
    chk("t5_out_data", act_d, 0);
    tick();
    bus.start = 0;
    wait_done(b_done, 40);
    chk("t5_last_pop", 64'(pop3_cyc), 64'(t0 + 9));
    chk("t5_drained", 64'(exp_q.size()), 0);
    tick();
    // ready toggling every cycle
    load(300);
    snap();
    bus.out_ready = 1;
    start_tile(0);
    for (int i = 0; i < 60 && done_cnt == b_done; i++) begin
      bus.out_ready = !bus.out_ready;
      tick();
    end
    bus.out_ready = 1;
    chk("t6_done_count", 64'(done_cnt - b_done), 1);
    chk("t6_first_pop", 64'(pop0_cyc), 64'(t0 + 6));
    chk("t6_last_pop", 64'(pop3_cyc), 64'(t0 + 12));
    chk("t6_drained", 64'(exp_q.size()), 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/drain_collector.md
DRAIN_COLLECTOR -- requirements
Module: drain_collector

Interface
- REQ-001: The module SHALL have parameter N, default 4, giving the array dimension (rows = columns).
- REQ-002: The module SHALL have parameter ACC_WIDTH, default 32, giving the accumulator width of the array.
- REQ-003: The module SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, giving the output element width.
- REQ-004: The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
- REQ-005: The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
- REQ-006: The module SHALL have port start, input, 1 bit, a one-cycle request to drain one tile.
- REQ-007: The module SHALL have port shift, input, 5 bits, the requantization right-shift, sampled on an accepted start.
- REQ-008: The module SHALL have port busy, output, 1 bit, high from an accepted start until done.
- REQ-009: The module SHALL have port done, output, 1 bit, a one-cycle pulse when the last row is accepted.
- REQ-010: The module SHALL have port drain_enable, output, 1 bit, the drain command to the systolic array.
- REQ-011: The module SHALL have port acc_clear, output, 1 bit, a one-cycle accumulator-clear pulse to the array.
- REQ-012: The module SHALL have port drain_data[N], input, ACC_WIDTH each, the skewed column outputs of the array.
- REQ-013: The module SHALL have port out_valid, output, 1 bit, marking a valid deskewed row.
- REQ-014: The module SHALL have port out_ready, input, 1 bit, the downstream accept signal.
- REQ-015: The module SHALL have port out_data[N], output, DATA_WIDTH each, one requantized result row.
- REQ-016: The module SHALL have port out_row, output, $clog2(N) bits, the index of the presented row.
- REQ-017: The module SHALL have port out_last, output, 1 bit, high when out_row equals N-1.

Function
- REQ-018: The module SHALL implement the states IDLE, DRAIN, FLUSH and DONE.
- REQ-019: The module SHALL accept start only in IDLE and ignore it in every other state, including the done cycle.
- REQ-020: Acceptance of start at cycle t0 SHALL move IDLE to DRAIN, with drain_enable high during cycles t0+1 through t0+2N-1 (2N-1 cycles).
- REQ-021: The module SHALL treat element (r,c) as valid on drain_data[c] at cycle t0+2+r+c.
- REQ-022: Column c SHALL pass through a delay of N-1-c cycles, so row r is aligned at cycle t0+N+1+r and is written into the row FIFO that cycle.
- REQ-023: The row FIFO SHALL hold N rows, so a full tile always fits and the array never needs to stall.
- REQ-024: Each element SHALL be arithmetically right-shifted by shift, truncated toward negative infinity, then saturated to the signed DATA_WIDTH range before the FIFO write.
- REQ-025: The module SHALL pulse acc_clear for exactly one cycle, the cycle after drain_enable falls; the state then moves DRAIN to FLUSH.
- REQ-026: In FLUSH, out_valid SHALL equal FIFO non-empty, and a row is popped when out_valid and out_ready are both high.
- REQ-027: Rows SHALL leave in order 0..N-1, and out_data, out_row and out_last SHALL be held stable while out_valid is high and out_ready is low.
- REQ-028: A FIFO push and pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
- REQ-029: Popping row N-1 SHALL move the state to DONE, where done is high for one cycle and busy is still high; DONE then returns to IDLE.
- REQ-030: Rows SHALL be streamed out as soon as they are available, without waiting for the drain window to end.

Reset
- REQ-031: While rst is high, the module SHALL force state to IDLE, empty the FIFO, clear the delay lines, and drive busy, done, drain_enable, acc_clear and out_valid to 0, out_row to 0 and out_data to 0.
- REQ-032: A reset asserted mid-operation SHALL abort the tile with no done pulse; start is accepted from the first cycle after rst falls.

Structure
- REQ-033: The state enum, the shift-and-saturate function and the ACC_WIDTH default SHALL live in the shared package alongside the defines.
- REQ-034: The N-entry row FIFO SHALL be a separate sub-module named row_fifo, and the deskew delay lines SHALL stay inline.

Verification
- REQ-035: With N=4, shift=0, element (r,c)=10r+c and out_ready held high, the bench SHALL see rows [0,1,2,3] through [30,31,32,33] in order, out_last on row 3, and done one cycle after that row.
- REQ-036: With out_ready low until the drain completes, the bench SHALL see all 4 rows retained and delivered in order once out_ready rises, with no loss.
- REQ-037: With shift=4 and elements 0x7FFF_0000, -0x7FFF_0000, 0x100 and -17, the outputs SHALL be 32767, -32768, 16 and -2 (DATA_WIDTH=16).
- REQ-038: A second start pulsed during DRAIN and during the done cycle SHALL be ignored, with drain_enable high for exactly 7 cycles and exactly one acc_clear pulse.
- REQ-039: rst asserted two cycles into DRAIN SHALL take all outputs to their reset values the next cycle with no done pulse, and a fresh start SHALL then complete normally.
- REQ-040: out_ready toggling 1,0,1,0 SHALL pop rows only on ready-high cycles, with out_data held stable across each stall.
